// File: rtl/cache_pkg.sv
// Shared types and constants for the cache and its memory-side refill controller.
package cache_pkg;

  localparam int RAM_ADDRESS_BITS = 10;
  localparam int DATA_BITS        = 32;
  localparam int BLOCK_BITS       = 2;
  localparam int BLOCK_SIZE       = 2 ** BLOCK_BITS;
  localparam int TAG_BITS         = RAM_ADDRESS_BITS - BLOCK_BITS;
  localparam int CNT_BITS         = BLOCK_BITS + 1;

  typedef logic [CNT_BITS-1:0]         cnt_t;
  typedef logic [DATA_BITS-1:0]        word_t;
  typedef logic [RAM_ADDRESS_BITS-1:0] addr_t;
  typedef logic [TAG_BITS-1:0]         block_id_t;

  // Word i of a block sits at element i (offset i within the block).
  typedef word_t block_data_t [BLOCK_SIZE-1:0];

  localparam cnt_t BLOCK_CNT = cnt_t'(BLOCK_SIZE);
  localparam cnt_t LAST_CNT  = cnt_t'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FILL,
    ST_DONE
  } refill_state_t;

  typedef struct packed {
    logic  valid;
    addr_t addr;
    word_t data;
  } write_buf_t;

  // Tag+index part of a word address; the offset bits are dropped.
  function automatic block_id_t block_of(input addr_t a);
    return a[RAM_ADDRESS_BITS-1:BLOCK_BITS];
  endfunction

endpackage

// File: rtl/refill_word_buf.sv
// Return counter and block assembly registers for one refill.
// Each accepted read return lands at the offset given by the return count.
module refill_word_buf
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,   // new fill begins: rewind the return counter
  input  logic        rvalid_i,  // read return belonging to the current fill
  input  word_t       rdata_i,
  output cnt_t        ret_cnt_o,
  output logic        last_o,    // this return completes the block
  output block_data_t data_o
);

  cnt_t        ret_cnt_q, ret_cnt_d;
  block_data_t data_q;

  // Next return count: rewind on start, advance on each return.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    ret_cnt_d = ret_cnt_q;
    if (start_i) begin
      ret_cnt_d = '0;
    end else if (rvalid_i) begin
      ret_cnt_d = ret_cnt_q + cnt_t'(1);
    end
  end

  // Return counter register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      ret_cnt_q <= '0;
    end else begin
      ret_cnt_q <= ret_cnt_d;
    end
  end

  // Block data registers; old contents stay until each word is overwritten.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: this storage is reset because it drives ram_data directly, which must read zero after reset.
    if (reset) begin
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        data_q[i] <= '0;
      end
    end else if (rvalid_i) begin
      data_q[ret_cnt_q[BLOCK_BITS-1:0]] <= rdata_i;
    end
  end

  assign ret_cnt_o = ret_cnt_q;
  assign last_o    = rvalid_i && (ret_cnt_q == LAST_CNT);
  assign data_o    = data_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Memory-side refill controller: block refills and single-word writebacks
// against a word-wide RAM port, with one buffered write and one fill in flight.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  addr_t       prop_address,
  input  logic        prop_read_en,
  input  logic        prop_write_en,
  input  word_t       prop_write_data,
  output logic        ram_valid,
  output block_data_t ram_data,
  output logic        busy,
  output logic        wr_overflow,
  output logic        mem_req,
  output logic        mem_we,
  output addr_t       mem_addr,
  output word_t       mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  word_t       mem_rdata
);

  localparam cnt_t MAX_OUT = cnt_t'(MAX_OUTSTANDING);

  refill_state_t state_q, state_d;
  block_id_t     base_q, base_d;
  cnt_t          issue_cnt_q, issue_cnt_d;
  write_buf_t    wbuf_q, wbuf_d;
  logic          wr_overflow_q, wr_overflow_d;
  logic          rearm_valid_q, rearm_valid_d;
  block_id_t     rearm_block_q, rearm_block_d;

  cnt_t ret_cnt;
  cnt_t outstanding;
  logic last_ret;
  logic fill_start;
  logic fill_rvalid;
  logic drain;
  logic wr_accept;
  logic rearm_hit;

  // Returns outside FILL (including stragglers from an aborted fill) are ignored.
  assign fill_rvalid = mem_rvalid && (state_q == ST_FILL);
  assign outstanding = issue_cnt_q - ret_cnt;
  assign rearm_hit   = rearm_valid_q && (block_of(prop_address) == rearm_block_q);

  refill_word_buf u_word_buf (
    .clk       (clk),
    .reset     (reset),
    .start_i   (fill_start),
    .rvalid_i  (fill_rvalid),
    .rdata_i   (mem_rdata),
    .ret_cnt_o (ret_cnt),
    .last_o    (last_ret),
    .data_o    (ram_data)
  );

  // FSM next state and RAM request generation.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    fill_start  = 1'b0;
    drain       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    ram_valid   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A write arriving now is captured this cycle; it goes ahead of any read.
        if (wbuf_q.valid || prop_write_en) begin
          state_d = ST_WRITE;
        end else if (prop_read_en && !rearm_hit) begin
          base_d      = block_of(prop_address);
          issue_cnt_d = '0;
          fill_start  = 1'b1;
          state_d     = ST_FILL;
        end
      end
      ST_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wbuf_q.addr;
        mem_wdata = wbuf_q.data;
        if (mem_ready) begin
          drain   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if ((issue_cnt_q < BLOCK_CNT) && (outstanding < MAX_OUT)) begin
          mem_req  = 1'b1;
          mem_addr = {base_q, issue_cnt_q[BLOCK_BITS-1:0]};
          if (mem_ready) begin
            issue_cnt_d = issue_cnt_q + cnt_t'(1);
          end
        end
        if (last_ret) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ram_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Single-entry write buffer; a write into a full, non-draining buffer is lost.
  always_comb begin
    wbuf_d        = wbuf_q;
    wr_overflow_d = wr_overflow_q;
    wr_accept     = prop_write_en && (!wbuf_q.valid || drain);
    if (drain) begin
      wbuf_d.valid = 1'b0;
    end
    if (wr_accept) begin
      wbuf_d = '{valid: 1'b1, addr: prop_address, data: prop_write_data};
    end else if (prop_write_en) begin
      wr_overflow_d = 1'b1;
    end
  end

  // Re-arm tracking: suppress re-fetch of the block just delivered while the read is held.
  always_comb begin
    rearm_valid_d = rearm_valid_q && prop_read_en;
    rearm_block_d = rearm_block_q;
    if (state_q == ST_DONE) begin
      rearm_valid_d = 1'b1;
      rearm_block_d = base_q;
    end
    if (wr_accept && (block_of(prop_address) == rearm_block_d)) begin
      rearm_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      issue_cnt_q   <= '0;
      wbuf_q        <= '0;
      wr_overflow_q <= 1'b0;
      rearm_valid_q <= 1'b0;
      rearm_block_q <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      issue_cnt_q   <= issue_cnt_d;
      wbuf_q        <= wbuf_d;
      wr_overflow_q <= wr_overflow_d;
      rearm_valid_q <= rearm_valid_d;
      rearm_block_q <= rearm_block_d;
    end
  end

  assign busy        = (state_q != ST_IDLE) || wbuf_q.valid;
  assign wr_overflow = wr_overflow_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: stimulus pushes expected RAM
// transactions and blocks; a negedge monitor pops and compares.
module tb_cache_refill_ctrl;
  import cache_pkg::*;

  localparam int MAX_OUT = 2;

  typedef logic [BLOCK_SIZE-1:0][DATA_BITS-1:0] blk_t;
  typedef struct {
    logic  we;
    addr_t addr;
    word_t data;
  } txn_t;
  typedef struct {
    int    due;
    word_t data;
  } ret_t;

  logic        clk = 1'b0;
  logic        reset;
  addr_t       prop_address;
  logic        prop_read_en;
  logic        prop_write_en;
  word_t       prop_write_data;
  logic        ram_valid;
  block_data_t ram_data;
  logic        busy;
  logic        wr_overflow;
  logic        mem_req;
  logic        mem_we;
  addr_t       mem_addr;
  word_t       mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  word_t       mem_rdata;

  txn_t  exp_txn[$];
  blk_t  exp_blk[$];
  ret_t  pending[$];
  word_t ram[1024];
  word_t model_mem[1024];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid = 0;
  int last_valid_cyc = 0;
  int n_req = 0;
  int n_rv = 0;
  int lat = 1;
  bit ready_toggle = 1'b0;
  bit rearm_v = 1'b0;
  block_id_t rearm_b = '0;

  always #5 clk = ~clk;

  cache_refill_ctrl #(.MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk             (clk),
    .reset           (reset),
    .prop_address    (prop_address),
    .prop_read_en    (prop_read_en),
    .prop_write_en   (prop_write_en),
    .prop_write_data (prop_write_data),
    .ram_valid       (ram_valid),
    .ram_data        (ram_data),
    .busy            (busy),
    .wr_overflow     (wr_overflow),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ready       (mem_ready),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RAM responder: ready pattern and in-order read returns after a fixed latency.
  always @(posedge clk) begin
    #1;
    mem_ready = ready_toggle ? cyc[0] : 1'b1;
    if (pending.size() > 0 && pending[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = pending[0].data;
      void'(pending.pop_front());
      n_rv++;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
  end

  // Monitor: compare accepted RAM requests and delivered blocks against the scoreboard.
  always @(negedge clk) begin : mon
    txn_t e;
    blk_t b;
    if (!reset) begin
      if (mem_req) n_req++;
      if (mem_req && mem_ready) begin
        check("req_expected", exp_txn.size() != 0, 1);
        if (exp_txn.size() != 0) begin
          e = exp_txn.pop_front();
          check("mem_we", mem_we, e.we);
          check("mem_addr", mem_addr, e.addr);
          if (e.we) check("mem_wdata", mem_wdata, e.data);
        end
        if (mem_we) begin
          ram[mem_addr] = mem_wdata;
        end else begin
          pending.push_back('{due: cyc + lat, data: ram[mem_addr]});
          check("outstanding_limit", pending.size() <= MAX_OUT, 1);
        end
      end
      if (ram_valid) begin
        n_valid++;
        last_valid_cyc = cyc;
        check("valid_expected", exp_blk.size() != 0, 1);
        if (exp_blk.size() != 0) begin
          b = exp_blk.pop_front();
          for (int i = 0; i < BLOCK_SIZE; i++) begin
            check($sformatf("ram_data[%0d]", i), ram_data[i], b[i]);
          end
        end
      end
    end
  end

  // Reference model: a read of a block not currently re-armed costs BLOCK_SIZE
  // ordered word reads and delivers the current memory image of that block.
  task automatic expect_read(input addr_t a);
    block_id_t blk_id;
    blk_t      blk;
    addr_t     ad;
    blk_id = block_of(a);
    if (rearm_v && rearm_b == blk_id) return;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      ad = {blk_id, i[BLOCK_BITS-1:0]};
      exp_txn.push_back('{we: 1'b0, addr: ad, data: '0});
      blk[i] = model_mem[ad];
    end
    exp_blk.push_back(blk);
    rearm_v = 1'b1;
    rearm_b = blk_id;
  endtask

  task automatic expect_write(input addr_t a, input word_t d);
    exp_txn.push_back('{we: 1'b1, addr: a, data: d});
    model_mem[a] = d;
    if (rearm_v && rearm_b == block_of(a)) rearm_v = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_read();
    prop_read_en = 1'b0;
    step(1);
    rearm_v = 1'b0;
  endtask

  task automatic wait_quiet(input string name, input int maxc);
    int k = 0;
    while ((exp_txn.size() != 0 || exp_blk.size() != 0 || busy || pending.size() != 0) && k < maxc) begin
      step(1);
      k++;
    end
    check({name, "_done_in_budget"}, k < maxc, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    addr_t a, w1, w2, last_w;
    word_t d;
    int t0, r0, v0, k;

    for (int i = 0; i < 1024; i++) begin
      ram[i]       = $urandom;
      model_mem[i] = ram[i];
    end
    reset = 1'b1;
    prop_address = '0; prop_read_en = 1'b0; prop_write_en = 1'b0; prop_write_data = '0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    step(3);
    check("rst_ram_valid", ram_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_overflow", wr_overflow, 0);
    check("rst_mem_req", mem_req, 0);
    for (int i = 0; i < BLOCK_SIZE; i++) check($sformatf("rst_ram_data[%0d]", i), ram_data[i], 0);
    reset = 1'b0;
    step(2);

    // 1: block refill of 0x013 with latency check.
    lat = 1;
    prop_address = 10'h013;
    prop_read_en = 1'b1;
    t0 = cyc;
    expect_read(10'h013);
    wait_quiet("t1", 60);
    check("t1_latency", last_valid_cyc - t0, BLOCK_SIZE + 2);

    // 2: read held on the same block must not re-fetch.
    r0 = n_req;
    step(10);
    check("t2_no_refetch", n_req - r0, 0);
    check("t2_busy", busy, 0);
    release_read();

    // 3: simultaneous write and read; write goes first.
    prop_address = 10'h021; prop_write_data = 32'hDEADBEEF;
    prop_write_en = 1'b1; prop_read_en = 1'b1;
    expect_write(10'h021, 32'hDEADBEEF);
    step(1);
    prop_write_en = 1'b0;
    prop_address = 10'h040;
    expect_read(10'h040);
    wait_quiet("t3", 60);
    release_read();

    // 4: two writes during a slow fill; second is lost.
    lat = 3;
    a = addr_t'($urandom);
    w1 = a ^ 10'h200;
    w2 = a ^ 10'h100;
    prop_address = a; prop_read_en = 1'b1;
    expect_read(a);
    step(2);
    check("t4_busy_in_fill", busy, 1);
    d = $urandom;
    prop_address = w1; prop_write_data = d; prop_write_en = 1'b1;
    expect_write(w1, d);
    step(1);
    prop_address = w2; prop_write_data = ~d;
    step(1);
    prop_write_en = 1'b0;
    prop_address = a;
    wait_quiet("t4", 80);
    check("t4_wr_overflow", wr_overflow, 1);
    release_read();
    prop_address = w2; prop_read_en = 1'b1;
    expect_read(w2);
    wait_quiet("t4_dropped_readback", 80);
    release_read();

    // 5: toggling ready, random latency, random reads/writes.
    ready_toggle = 1'b1;
    last_w = '0;
    for (int n = 0; n < 10; n++) begin
      lat = $urandom_range(1, 4);
      k = $urandom_range(0, 2);
      a = (k == 2) ? last_w : addr_t'($urandom);
      if (k == 0) begin
        d = $urandom;
        prop_address = a; prop_write_data = d; prop_write_en = 1'b1;
        expect_write(a, d);
        last_w = a;
        step(1);
        prop_write_en = 1'b0;
        wait_quiet("t5_write", 80);
      end else begin
        prop_address = a; prop_read_en = 1'b1;
        expect_read(a);
        wait_quiet("t5_read", 120);
        release_read();
      end
    end
    ready_toggle = 1'b0;

    // 6: reset in the middle of a fill.
    lat = 2;
    a = addr_t'($urandom);
    prop_address = a; prop_read_en = 1'b1;
    expect_read(a);
    r0 = n_rv;
    k = 0;
    while (n_rv - r0 < 2 && k < 40) begin
      step(1);
      k++;
    end
    check("t6_two_returns_in_budget", k < 40, 1);
    v0 = n_valid;
    reset = 1'b1;
    #1;
    check("t6_rst_mem_req", mem_req, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ram_valid", ram_valid, 0);
    check("t6_rst_ram_data0", ram_data[0], 0);
    exp_txn.delete();
    exp_blk.delete();
    rearm_v = 1'b0;
    prop_read_en = 1'b0;
    step(2);
    reset = 1'b0;
    k = 0;
    while (pending.size() != 0 && k < 20) begin
      step(1);
      k++;
    end
    step(3);
    check("t6_no_valid_after_abort", n_valid - v0, 0);
    check("t6_ram_data1_untouched", ram_data[1], 0);
    check("t6_wr_overflow_cleared", wr_overflow, 0);
    a = addr_t'($urandom);
    prop_address = a; prop_read_en = 1'b1;
    expect_read(a);
    wait_quiet("t6_new_fill", 60);
    check("t6_new_fill_delivered", n_valid - v0, 1);
    release_read();

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
